// File: rtl/nibble_pkg.sv
// Shared constants for the nibble adder datapath.
package nibble_pkg;

  // Nibble width, and the width of a nibble sum with its carry-out.
  localparam int NIBBLE_W = 4;
  localparam int SUM_W    = NIBBLE_W + 1;

  // Nibble select encoding for ctrl.
  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;

endpackage : nibble_pkg

// File: rtl/nibble_rca.sv
// Combinational ripple-carry adder built from explicit full-adder cells.
// The carry chain is visible bit by bit instead of being folded into a '+'.
module nibble_rca #(
  parameter int NIBBLE_W = 4
) (
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  // carry[i] is the carry into bit i; carry[NIBBLE_W] leaves the adder.
  logic [NIBBLE_W:0] carry;

  assign carry[0] = cin;

  // One full-adder cell per bit, each feeding its carry to the next.
  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[NIBBLE_W];

endmodule : nibble_rca

// File: rtl/nibble_add.sv
// Registered nibble adder: selects the low or high nibbles of A and B,
// adds them with a ripple-carry chain and registers {carry, sum}.
module nibble_add #(
  parameter int NIBBLE_W = nibble_pkg::NIBBLE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*NIBBLE_W-1:0] A,
  input  logic [2*NIBBLE_W-1:0] B,
  input  logic                  ctrl,
  output logic [NIBBLE_W:0]     q
);

  import nibble_pkg::SEL_HI;

  logic [NIBBLE_W-1:0] a_sel;
  logic [NIBBLE_W-1:0] b_sel;
  logic [NIBBLE_W-1:0] sum;
  logic                cout;

  // Operand mux: pick the nibble pair named by ctrl from the current operands.
  // NOTE: defaults are assigned first so every path drives a_sel/b_sel and
  // no latch is inferred.
  always_comb begin
    a_sel = A[NIBBLE_W-1:0];
    b_sel = B[NIBBLE_W-1:0];
    if (ctrl == SEL_HI) begin
      a_sel = A[2*NIBBLE_W-1:NIBBLE_W];
      b_sel = B[2*NIBBLE_W-1:NIBBLE_W];
    end
  end

  // Unsigned add with no carry-in; the carry-out becomes the top result bit.
  nibble_rca #(
    .NIBBLE_W (NIBBLE_W)
  ) u_rca (
    .a    (a_sel),
    .b    (b_sel),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // Result register, cleared asynchronously while rst_n is low.
  // NOTE: non-blocking assignment so q updates as a true flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= {cout, sum};
    end
  end

endmodule : nibble_add

// File: tb/tb_nibble_add.sv
// Directed testbench for nibble_add: reset, nibble selection, carries,
// async clear, back-to-back changes and a short randomised run.
module tb_nibble_add;

  logic       clk;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic       ctrl;
  logic [4:0] q;

  int total;
  int bad;

  nibble_add #(.NIBBLE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .ctrl  (ctrl),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, take one rising edge, then compare q just after it.
  task automatic step(input logic c, input logic [7:0] a, input logic [7:0] b,
                      input logic [4:0] exp, input string name);
    ctrl = c;
    A    = a;
    B    = b;
    @(posedge clk);
    #1;
    total++;
    if (q !== exp) begin
      bad++;
      $display("FAIL %s: q=%h expected=%h", name, q, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ctrl  = 1'b0;
    A     = 8'hFF;
    B     = 8'hFF;
    #1;
    total++;
    if (q !== 5'h00) begin
      bad++;
      $display("FAIL reset_async: q=%h expected=00", q);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (q !== 5'h00) begin
        bad++;
        $display("FAIL reset_hold%0d: q=%h expected=00", i, q);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'hFF, 8'hFF, 5'h1E, "reset_release");
  endtask

  task automatic test_low_high();
    step(1'b0, 8'h3C, 8'h25, 5'h11, "low_carry");
    step(1'b1, 8'h3C, 8'h25, 5'h05, "high");
  endtask

  task automatic test_alternate();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) step(1'b0, 8'h3C, 8'h25, 5'h11, "alt_low");
      else            step(1'b1, 8'h3C, 8'h25, 5'h05, "alt_high");
    end
  endtask

  task automatic test_extremes();
    step(1'b0, 8'h0F, 8'h0F, 5'h1E, "max_low");
    step(1'b1, 8'hF0, 8'hF0, 5'h1E, "max_high");
    step(1'b1, 8'h0F, 8'h0F, 5'h00, "ignored_low");
    step(1'b0, 8'hF1, 8'hF2, 5'h03, "ignored_high");
  endtask

  task automatic test_back_to_back();
    step(1'b0, 8'h3C, 8'h25, 5'h11, "b2b_0");
    step(1'b1, 8'hF0, 8'hF0, 5'h1E, "b2b_1");
    step(1'b0, 8'hF7, 8'hF8, 5'h0F, "b2b_2");
    step(1'b1, 8'h9A, 8'h6B, 5'h0F, "b2b_3");
  endtask

  task automatic test_async_reset();
    step(1'b1, 8'h81, 8'h71, 5'h0F, "pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (q !== 5'h00) begin
      bad++;
      $display("FAIL midstream_reset: q=%h expected=00", q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h81, 8'h71, 5'h0F, "post_reset");
  endtask

  task automatic test_random();
    logic [7:0] ra;
    logic [7:0] rb;
    logic [4:0] exp;
    for (int i = 0; i < 10; i++) begin
      logic c;
      c   = (i >= 5);
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      exp = c ? ({1'b0, ra[7:4]} + {1'b0, rb[7:4]})
              : ({1'b0, ra[3:0]} + {1'b0, rb[3:0]});
      step(c, ra, rb, exp, "random");
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_low_high();
    test_alternate();
    test_extremes();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_nibble_add
